// File: rtl/sandpile_grid_store_if.sv
// Bus bundle between the sandpile engine/renderer and the grid cell store.
// Carries the renderer read port, the engine write handshake and the clear control.
interface sandpile_grid_store_if #(
    parameter int MAX_SIZE = 32,
    parameter int DATA_W   = 3
);
    localparam int AW = $clog2(MAX_SIZE);

    logic [8:0]        grid_size;
    logic [AW-1:0]     rd_addr_x;
    logic [AW-1:0]     rd_addr_y;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr_x;
    logic [AW-1:0]     wr_addr_y;
    logic [DATA_W-1:0] wr_data;
    logic              clear_req;
    logic              busy;

    // Engine/renderer side
    modport master (
        output grid_size, rd_addr_x, rd_addr_y, wr_valid, wr_addr_x, wr_addr_y,
               wr_data, clear_req,
        input  rd_data, wr_ready, busy
    );

    // Store side
    modport slave (
        input  grid_size, rd_addr_x, rd_addr_y, wr_valid, wr_addr_x, wr_addr_y,
               wr_data, clear_req,
        output rd_data, wr_ready, busy
    );
endinterface

// File: rtl/sandpile_grid_store.sv
// Grid cell store for the sandpile display path.
// One block RAM of MAX_SIZE^2 cells indexed {y,x}; registered read for the
// renderer, valid/ready write for the engine, and a zeroing sweep that runs
// out of reset and on clear_req.
module sandpile_grid_store #(
    parameter int MAX_SIZE = 32,
    parameter int DATA_W   = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    sandpile_grid_store_if.slave  bus
);
    localparam int AW    = $clog2(MAX_SIZE);
    localparam int IW    = 2 * AW;
    localparam int DEPTH = MAX_SIZE * MAX_SIZE;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IW-1:0]     ctr_reg;
    logic [IW-1:0]     ctr_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              wr_ready_int;
    logic              busy_int;

    logic [DATA_W-1:0] mem [DEPTH];

    // Cells whose column or row reaches grid_size lie outside the active grid.
    logic rd_inside;
    logic wr_inside;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic wr_fire;

    assign rd_inside = (32'(bus.rd_addr_x) < 32'(bus.grid_size)) &&
                       (32'(bus.rd_addr_y) < 32'(bus.grid_size));
    assign wr_inside = (32'(bus.wr_addr_x) < 32'(bus.grid_size)) &&
                       (32'(bus.wr_addr_y) < 32'(bus.grid_size));
    assign rd_idx    = {bus.rd_addr_y, bus.rd_addr_x};
    assign wr_idx    = {bus.wr_addr_y, bus.wr_addr_x};
    // Handshake completes even for outside cells; only inside ones are stored.
    assign wr_fire   = bus.wr_valid && wr_ready_int;

    // State register and sweep counter; reset restarts the sweep from cell 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_CLEAR;
            ctr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ctr_reg   <= ctr_next;
        end
    end

    // Next-state: sweep until the last cell, clear_req only honoured in RUN.
    always_comb begin
        state_next = state_reg;
        ctr_next   = ctr_reg;
        case (state_reg)
            ST_CLEAR: begin
                ctr_next = ctr_reg + 1'b1;
                if (ctr_reg == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_next = ST_CLEAR;
                    ctr_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                ctr_next   = '0;
            end
        endcase
    end

    // Outputs decoded from state: writes blocked and busy raised while sweeping.
    always_comb begin
        wr_ready_int = 1'b0;
        busy_int     = 1'b1;
        if (state_reg == ST_RUN) begin
            wr_ready_int = 1'b1;
            busy_int     = 1'b0;
        end
    end

    // RAM write port: sweep zeroes in CLEAR, engine writes in RUN (exclusive via wr_ready).
    always_ff @(posedge clk) begin
        if (state_reg == ST_CLEAR) begin
            mem[ctr_reg] <= '0;
        end else if (wr_fire && wr_inside) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end

    // Registered read; sees pre-write contents, forced to 0 while clearing or outside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if ((state_reg == ST_CLEAR) || !rd_inside) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.wr_ready = wr_ready_int;
    assign bus.busy     = busy_int;
endmodule

// File: tb/tb_sandpile_grid_store.sv
// Self-checking bench for sandpile_grid_store: directed scenarios plus a
// randomized run against an array model of the grid.
module tb_sandpile_grid_store;
    localparam int N     = 32;
    localparam int CELLS = N * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sandpile_grid_store_if #(.MAX_SIZE(N), .DATA_W(3)) bus ();

    sandpile_grid_store #(.MAX_SIZE(N), .DATA_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int model [CELLS];
    int gs    = 32;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_in(int x, int y, int g);
        return (x < g) && (y < g);
    endfunction

    function automatic int expect_rd(int x, int y);
        return is_in(x, y, gs) ? model[y * N + x] : 0;
    endfunction

    task automatic set_grid(int g);
        gs = g;
        bus.grid_size = 9'(g);
    endtask

    task automatic set_read(int x, int y);
        bus.rd_addr_x = 5'(x);
        bus.rd_addr_y = 5'(y);
    endtask

    task automatic set_write(int x, int y, int d);
        bus.wr_valid  = 1'b1;
        bus.wr_addr_x = 5'(x);
        bus.wr_addr_y = 5'(y);
        bus.wr_data   = 3'(d);
    endtask

    // Single write transaction; the model follows the store rules.
    task automatic do_write(int x, int y, int d);
        set_write(x, y, d);
        tick();
        bus.wr_valid = 1'b0;
        if (is_in(x, y, gs)) model[y * N + x] = d;
        $display("write (%0d,%0d)=%0d grid_size=%0d", x, y, d, gs);
    endtask

    task automatic test_reset();
        int n;
        bus.wr_valid = 1'b0;
        bus.clear_req = 1'b0;
        bus.wr_addr_x = '0; bus.wr_addr_y = '0; bus.wr_data = '0;
        set_read(0, 0);
        set_grid(32);
        #2 rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.rd_data !== 3'd0) begin
            bad++;
            $display("FAIL reset_state busy=%b wr_ready=%b rd_data=%0d required 1/0/0",
                     bus.busy, bus.wr_ready, bus.rd_data);
        end
        rst_n = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        total++;
        if (n != 1024 || bus.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_sweep_len cycles=%0d wr_ready=%b required 1024/1", n, bus.wr_ready);
        end
        $display("reset sweep finished after %0d cycles", n);
        for (int i = 0; i < CELLS; i++) model[i] = 0;
        for (int i = 0; i < CELLS; i++) begin
            set_read(i % N, i / N);
            tick();
            total++;
            if (bus.rd_data !== 3'd0) begin
                bad++;
                $display("FAIL reset_read cell=%0d got=%0d required 0", i, bus.rd_data);
            end
        end
    endtask

    task automatic test_write_read();
        int e;
        set_grid(32);
        total++;
        if (bus.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_ready_run got=%b required 1", bus.wr_ready);
        end
        do_write(3, 5, 6);
        set_read(3, 5);
        e = expect_rd(3, 5);
        tick();
        total++;
        if (bus.rd_data !== 3'(e)) begin
            bad++;
            $display("FAIL read_3_5 got=%0d required %0d", bus.rd_data, e);
        end
        $display("read (3,5)=%0d", bus.rd_data);
        set_read(5, 3);
        e = expect_rd(5, 3);
        tick();
        total++;
        if (bus.rd_data !== 3'(e)) begin
            bad++;
            $display("FAIL read_5_3 got=%0d required %0d", bus.rd_data, e);
        end
        $display("read (5,3)=%0d", bus.rd_data);
    endtask

    task automatic test_read_before_write();
        int old_v;
        do_write(7, 7, 5);
        old_v = expect_rd(7, 7);
        set_write(7, 7, 2);
        set_read(7, 7);
        tick();
        bus.wr_valid = 1'b0;
        model[7 * N + 7] = 2;
        total++;
        if (bus.rd_data !== 3'(old_v)) begin
            bad++;
            $display("FAIL rbw_old got=%0d required %0d", bus.rd_data, old_v);
        end
        $display("write+read (7,7): read %0d", bus.rd_data);
        tick();
        total++;
        if (bus.rd_data !== 3'(expect_rd(7, 7))) begin
            bad++;
            $display("FAIL rbw_new got=%0d required %0d", bus.rd_data, expect_rd(7, 7));
        end
        $display("read (7,7)=%0d", bus.rd_data);
    endtask

    task automatic test_grid_bounds();
        int e;
        set_grid(32);
        do_write(20, 4, 1);
        do_write(0, 0, 3);
        set_grid(16);
        set_write(20, 4, 7);
        total++;
        if (bus.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL outside_handshake wr_ready=%b required 1", bus.wr_ready);
        end
        do_write(20, 4, 7);
        set_read(20, 4);
        tick();
        total++;
        if (bus.rd_data !== 3'd0) begin
            bad++;
            $display("FAIL outside_read got=%0d required 0", bus.rd_data);
        end
        set_grid(32);
        e = expect_rd(20, 4);
        tick();
        total++;
        if (bus.rd_data !== 3'(e)) begin
            bad++;
            $display("FAIL dropped_write got=%0d required %0d", bus.rd_data, e);
        end
        $display("read (20,4) after grid_size=32: %0d", bus.rd_data);
        set_grid(0);
        set_read(0, 0);
        tick();
        total++;
        if (bus.rd_data !== 3'd0) begin
            bad++;
            $display("FAIL grid_zero got=%0d required 0", bus.rd_data);
        end
        set_grid(300);
        do_write(31, 31, 5);
        set_read(31, 31);
        e = expect_rd(31, 31);
        tick();
        total++;
        if (bus.rd_data !== 3'(e)) begin
            bad++;
            $display("FAIL grid_large got=%0d required %0d", bus.rd_data, e);
        end
        set_grid(31);
        set_read(31, 0);
        tick();
        total++;
        if (bus.rd_data !== 3'd0) begin
            bad++;
            $display("FAIL edge_outside got=%0d required 0", bus.rd_data);
        end
        set_read(0, 0);
        e = expect_rd(0, 0);
        tick();
        total++;
        if (bus.rd_data !== 3'(e)) begin
            bad++;
            $display("FAIL edge_inside got=%0d required %0d", bus.rd_data, e);
        end
        set_grid(32);
    endtask

    task automatic test_clear();
        int n;
        set_grid(32);
        for (int i = 0; i < CELLS; i++) begin
            set_write(i % N, i / N, 4);
            tick();
            model[i] = 4;
        end
        bus.wr_valid = 1'b0;
        set_read(9, 9);
        tick();
        total++;
        if (bus.rd_data !== 3'd4) begin
            bad++;
            $display("FAIL fill_check got=%0d required 4", bus.rd_data);
        end
        set_write(1, 1, 3);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        bus.wr_valid  = 1'b0;
        $display("clear_req with write (1,1)=3");
        total++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_start busy=%b wr_ready=%b required 1/0", bus.busy, bus.wr_ready);
        end
        set_read(31, 31);
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin
            if (n == 500) bus.clear_req = 1'b1;
            if (n == 1000) set_write(0, 0, 7);
            tick();
            bus.clear_req = 1'b0;
            n++;
            total++;
            if (bus.rd_data !== 3'd0) begin
                bad++;
                $display("FAIL clear_read_busy n=%0d got=%0d required 0", n, bus.rd_data);
            end
        end
        bus.wr_valid = 1'b0;
        total++;
        if (n != 1024) begin
            bad++;
            $display("FAIL clear_len cycles=%0d required 1024", n);
        end
        $display("clear sweep finished after %0d cycles", n);
        for (int i = 0; i < CELLS; i++) model[i] = 0;
        for (int i = 0; i < CELLS; i++) begin
            set_read(i % N, i / N);
            tick();
            total++;
            if (bus.rd_data !== 3'd0) begin
                bad++;
                $display("FAIL clear_read cell=%0d got=%0d required 0", i, bus.rd_data);
            end
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        do_write(2, 2, 6);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (300) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0 || bus.rd_data !== 3'd0) begin
            bad++;
            $display("FAIL midclear_reset busy=%b wr_ready=%b rd=%0d required 1/0/0",
                     bus.busy, bus.wr_ready, bus.rd_data);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        total++;
        if (n != 1024) begin
            bad++;
            $display("FAIL midclear_len cycles=%0d required 1024", n);
        end
        $display("sweep after mid-clear reset took %0d cycles", n);
        for (int i = 0; i < CELLS; i++) model[i] = 0;
        set_read(2, 2);
        tick();
        total++;
        if (bus.rd_data !== 3'd0) begin
            bad++;
            $display("FAIL midclear_read got=%0d required 0", bus.rd_data);
        end
    endtask

    task automatic test_random();
        int rx, ry, wx, wy, wd, e;
        bit wv;
        for (int c = 0; c < 600; c++) begin
            if ((c % 100) == 0) begin
                case ($urandom_range(0, 3))
                    0: set_grid(0);
                    1: set_grid(300);
                    default: set_grid(int'($urandom_range(1, 40)));
                endcase
            end
            rx = int'($urandom_range(0, N - 1));
            ry = int'($urandom_range(0, N - 1));
            wx = ($urandom_range(0, 1) == 1) ? rx : int'($urandom_range(0, N - 1));
            wy = ($urandom_range(0, 1) == 1) ? ry : int'($urandom_range(0, N - 1));
            wd = int'($urandom_range(0, 7));
            wv = ($urandom_range(0, 2) != 0);
            set_read(rx, ry);
            set_write(wx, wy, wd);
            bus.wr_valid = wv;
            e = expect_rd(rx, ry);
            total++;
            if (bus.wr_ready !== 1'b1) begin
                bad++;
                $display("FAIL rand_ready c=%0d got=%b required 1", c, bus.wr_ready);
            end
            tick();
            if (wv && is_in(wx, wy, gs)) model[wy * N + wx] = wd;
            total++;
            if (bus.rd_data !== 3'(e)) begin
                bad++;
                $display("FAIL rand_read c=%0d (%0d,%0d) gs=%0d got=%0d required %0d",
                         c, rx, ry, gs, bus.rd_data, e);
            end
        end
        bus.wr_valid = 1'b0;
        $display("random phase: 600 cycles");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_before_write();
        test_grid_bounds();
        test_clear();
        test_reset_midclear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
